// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- instruction fetch control.
//
// Selects the next fetch PC source each cycle and sequences FENCE.I:
//   RUN -> INVAL (1 cycle, invalidate icache + fetch buffer)
//       -> INVAL_WAIT (until icache_inval_ack_i) -> RESUME (1 cycle, JUMP) -> RUN
// A debug redirect aborts the sequence from any state.
//
// Optional feature (macro FETCH_CTRL_TIMEOUT_EN): an outstanding icache request
// that gets no response for TIMEOUT_CYCLES cycles raises retry_fetch_o.
// Without the macro retry_fetch_o is tied low.
//
// Ports:
//   clk_i, rstn_i                         clock, async active-low reset
//   stall_i, stall_debug_i                pipeline stall / debug halt
//   jump_commit_i, jump_debug_i           commit / debug redirect
//   fence_i_req_i, icache_inval_ack_i     FENCE.I request / invalidation done
//   icache_req_valid_i, icache_resp_valid_i  request issued / response returned
//   next_pc_sel_o                         0 KEEP_PC, 1 BP_OR_PC_4, 2 JUMP, 3 DEBUG
//   invalidate_icache_o, invalidate_buffer_o, retry_fetch_o, busy_o
module if_fetch_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       stall_i,
  input  logic       stall_debug_i,
  input  logic       jump_commit_i,
  input  logic       jump_debug_i,
  input  logic       fence_i_req_i,
  input  logic       icache_inval_ack_i,
  input  logic       icache_req_valid_i,
  input  logic       icache_resp_valid_i,
  output logic [1:0] next_pc_sel_o,
  output logic       invalidate_icache_o,
  output logic       invalidate_buffer_o,
  output logic       retry_fetch_o,
  output logic       busy_o
);

  localparam logic [1:0] SEL_KEEP  = 2'd0;
  localparam logic [1:0] SEL_PC4   = 2'd1;
  localparam logic [1:0] SEL_JUMP  = 2'd2;
  localparam logic [1:0] SEL_DEBUG = 2'd3;

  typedef enum logic [1:0] {RUN, INVAL, INVAL_WAIT, RESUME} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel;
  logic       inval, busy;
  logic       flush;     // redirect or invalidation: drop outstanding/counter
  logic       tmo;       // timeout retry this cycle
  logic       out_q, out_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= RUN;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = SEL_KEEP;
    inval   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_debug_i)                        sel = SEL_DEBUG;
        else if (jump_commit_i)                  sel = SEL_JUMP;
        else if (stall_i || stall_debug_i || fence_i_req_i || tmo) sel = SEL_KEEP;
        else                                     sel = SEL_PC4;
        // FENCE.I rides along with a commit jump but yields to debug
        if (fence_i_req_i && !jump_debug_i) begin
          busy    = 1'b1;
          state_d = INVAL;
        end
      end
      INVAL: begin
        inval   = 1'b1;
        busy    = 1'b1;
        sel     = jump_debug_i ? SEL_DEBUG : SEL_KEEP;
        state_d = jump_debug_i ? RUN : INVAL_WAIT;
      end
      INVAL_WAIT: begin
        busy = 1'b1;
        sel  = jump_debug_i ? SEL_DEBUG : SEL_KEEP;
        if (jump_debug_i)            state_d = RUN;
        else if (icache_inval_ack_i) state_d = RESUME;
      end
      RESUME: begin
        // commit holds fence PC+4 on pc_jump
        busy    = 1'b1;
        sel     = jump_debug_i ? SEL_DEBUG : SEL_JUMP;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign flush = (sel == SEL_JUMP) || (sel == SEL_DEBUG) || (state_q == INVAL);

  // Clear beats set; a same-cycle request and response leave the flag set.
  always_comb begin
    out_d = out_q;
    if (flush || tmo)             out_d = 1'b0;
    else if (icache_req_valid_i)  out_d = 1'b1;
    else if (icache_resp_valid_i) out_d = 1'b0;
  end

`ifdef FETCH_CTRL_TIMEOUT_EN
  logic [4:0] cnt_q, cnt_d;
  logic       pend;

  // A request issued this cycle already counts as outstanding.
  assign pend = out_q || icache_req_valid_i;
  assign tmo  = (state_q == RUN) && !jump_debug_i && !jump_commit_i && pend &&
                !icache_resp_valid_i && (cnt_q == 5'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (flush || tmo || icache_resp_valid_i) cnt_d = '0;
    else if (state_q == RUN && pend)         cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_out;
  assign tmo        = 1'b0;
  assign unused_out = out_q;
`endif

  // Outputs are forced to reset values while reset is held.
  assign next_pc_sel_o       = rstn_i ? sel : SEL_KEEP;
  assign invalidate_icache_o = rstn_i & inval;
  assign invalidate_buffer_o = rstn_i & inval;
  assign retry_fetch_o       = rstn_i & tmo;
  assign busy_o              = rstn_i & busy;

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning cycles an icache request may stay outstanding before a retry; legal range 2..31.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports stall_i and stall_debug_i, input, 1 each, pipeline stall and debug halt.
REQ-005 SHALL have port jump_commit_i, input, 1, commit redirect; pc_jump is valid this cycle.
REQ-006 SHALL have port jump_debug_i, input, 1, debug redirect.
REQ-007 SHALL have port fence_i_req_i, input, 1, single-cycle FENCE.I request from commit.
REQ-008 SHALL have port icache_inval_ack_i, input, 1, icache has finished invalidation.
REQ-009 SHALL have ports icache_req_valid_i and icache_resp_valid_i, input, 1 each, request issued and response returned.
REQ-010 SHALL have port next_pc_sel_o, output, 2, encoding KEEP_PC=0, BP_OR_PC_4=1, JUMP=2, DEBUG=3.
REQ-011 SHALL have ports invalidate_icache_o, invalidate_buffer_o, retry_fetch_o, busy_o, output, 1 each.

Function
REQ-012 SHALL implement FSM states RUN, INVAL, INVAL_WAIT, RESUME.
REQ-013 In RUN, next_pc_sel_o SHALL follow the priority jump_debug_i (DEBUG) > jump_commit_i (JUMP) > stall_i or stall_debug_i (KEEP_PC) > BP_OR_PC_4.
REQ-014 fence_i_req_i in RUN without a redirect SHALL select KEEP_PC and move to INVAL next cycle.
REQ-015 fence_i_req_i together with jump_commit_i SHALL take the jump this cycle and still move to INVAL.
REQ-016 INVAL SHALL last exactly one cycle, assert invalidate_icache_o and invalidate_buffer_o, select KEEP_PC, then move to INVAL_WAIT.
REQ-017 INVAL_WAIT SHALL select KEEP_PC and move to RESUME on the first cycle icache_inval_ack_i=1; it has no timeout.
REQ-018 RESUME SHALL last one cycle, select JUMP (commit holds fence PC+4 on pc_jump), then return to RUN.
REQ-019 jump_debug_i in any non-RUN state SHALL select DEBUG, abort the sequence and return to RUN; a later ack is ignored.
REQ-020 jump_commit_i in INVAL_WAIT or RESUME SHALL be ignored; commit stays stalled while busy_o=1.
REQ-021 busy_o SHALL be 1 in INVAL, INVAL_WAIT and RESUME, and also in the RUN cycle where fence_i_req_i is accepted.
REQ-022 An outstanding flag SHALL set on icache_req_valid_i and clear on icache_resp_valid_i; if both are 1 in one cycle, the flag stays set.
REQ-023 Any redirect (DEBUG or JUMP) or INVAL SHALL clear the outstanding flag and the timeout counter.
REQ-024 All outputs SHALL be registered-state decodes or combinational from inputs with zero latency; next_pc_sel_o takes effect on the fetch PC at the next edge.

Reset
REQ-025 On rstn_i=0: state=RUN, outstanding=0, counter=0; next_pc_sel_o=KEEP_PC; invalidate_icache_o, invalidate_buffer_o, retry_fetch_o and busy_o=0.
REQ-026 Reset asserted mid-sequence SHALL abandon it immediately; there is no resume after reset.
REQ-027 The first cycle after reset release SHALL follow REQ-013.

Configuration
REQ-028 Macro FETCH_CTRL_TIMEOUT_EN SHALL control the timeout retry logic.
REQ-029 With FETCH_CTRL_TIMEOUT_EN defined: a 5-bit counter increments each cycle while outstanding=1 in RUN without a response.
- When the counter reaches TIMEOUT_CYCLES-1: retry_fetch_o pulses for one cycle, the counter clears, outstanding clears, and next_pc_sel_o=KEEP_PC in that cycle.
- A response clears the counter.
REQ-030 Without FETCH_CTRL_TIMEOUT_EN: no counter is present and retry_fetch_o is tied to 0.

Verification
REQ-031 Reset then idle, no stalls -> next_pc_sel_o=1 every cycle, all pulses 0.
REQ-032 fence_i_req_i at cycle 5, ack at cycle 9 -> next_pc_sel_o=0 for cycles 5..9, invalidate pulse at cycle 6, JUMP at cycle 10, busy_o high cycles 5..10.
REQ-033 jump_debug_i=1 during INVAL_WAIT -> DEBUG that cycle, state RUN, a later ack has no effect.
REQ-034 jump_debug_i, jump_commit_i and stall_i all 1 in RUN -> next_pc_sel_o=3.
REQ-035 With FETCH_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: request at cycle 0, no response -> retry_fetch_o=1 only at cycle 15; response at cycle 10 -> no retry.
REQ-036 Reset asserted during INVAL_WAIT -> all outputs at reset values; after release, behaviour follows REQ-031.
